// File: rtl/crc_arb_pkg.sv
// -----------------------------------------------------------------------------
// crc_arb_pkg
// Shared definitions for the CRC-sharing arbiter:
//   DW, CRCW   : fixed data word and CRC widths (the CRC step below is built
//                for exactly 32 data bits into a 4-bit CRC)
//   state_t    : packet FSM states IDLE / DATA / TRAIL
//   crc4_step  : one 32-bit CRC-4 update, polynomial x^4+x+1, MSB first,
//                no reflection, no final XOR
// -----------------------------------------------------------------------------
package crc_arb_pkg;

    localparam int DW   = 32;
    localparam int CRCW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        TRAIL = 2'd2
    } state_t;

    // Bit-serial LFSR unrolled over the whole word; d[31] enters first.
    function automatic logic [CRCW-1:0] crc4_step(input logic [CRCW-1:0] crc,
                                                  input logic [DW-1:0]   d);
        logic [CRCW-1:0] c;
        logic            fb;
        c = crc;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_share_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Returns the first asserted request at or
// after ptr, searching upward and wrapping past N_REQ-1 back to 0.
// Ports:
//   req     in  N_REQ          request vector
//   ptr     in  clog2(N_REQ)   highest-priority index for this pick
//   gnt_idx out clog2(N_REQ)   picked index (0 when nothing is requested)
//   any     out 1              at least one request is asserted
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     any
);

    localparam int IDX_W = $clog2(N_REQ);

    // Walk the priority order from lowest to highest priority so the last
    // hit written is the highest-priority requester.
    always_comb begin
        int j;
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req[j]) begin
                gnt_idx = IDX_W'(j);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crc_share_arbiter.sv
// -----------------------------------------------------------------------------
// crc_share_arbiter
// Shares one CRC-4 engine between N_REQ packet sources. A round-robin grant is
// held for a whole packet; every accepted word is emitted as {word, running
// CRC} and each packet ends with a trailer beat {0, final CRC}. Packets that
// reach MAX_LEN words without LAST are force-closed and flagged.
//
// Optional build macro: CRC_ARB_PKTCNT_EN adds PKT_CNT, a wrapping 16-bit
// count of trailer beats accepted downstream.
//
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   REQ_VALID    per-requester word valid
//   REQ_LAST     per-requester last-word flag (qualified by REQ_VALID)
//   REQ_DATA     requester i word at [i*DW +: DW]
//   REQ_READY    per-requester accept
//   OUT_VALID    output beat valid
//   OUT_READY    downstream accept
//   OUT_DATA     {word, crc} data beat or {0, crc} trailer beat
//   OUT_LAST     high on trailer beat
//   OUT_SRC      granted requester index for the beat
//   ERR_OVERLEN  one-cycle pulse on a MAX_LEN forced close
//   PKT_CNT      (CRC_ARB_PKTCNT_EN only) accepted trailer count
// -----------------------------------------------------------------------------
module crc_share_arbiter
    import crc_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_LEN = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_REQ-1:0]         REQ_VALID,
    input  logic [N_REQ-1:0]         REQ_LAST,
    input  logic [N_REQ*DW-1:0]      REQ_DATA,
    output logic [N_REQ-1:0]         REQ_READY,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [DW+CRCW-1:0]       OUT_DATA,
    output logic                     OUT_LAST,
    output logic [$clog2(N_REQ)-1:0] OUT_SRC,
    output logic                     ERR_OVERLEN
`ifdef CRC_ARB_PKTCNT_EN
    ,
    output logic [15:0]              PKT_CNT
`endif
);

    localparam int                IDX_W    = $clog2(N_REQ);
    localparam int                LEN_W    = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      g_q, g_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CRCW-1:0]       crc_q, crc_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  out_valid_q, out_valid_d;
    logic [DW+CRCW-1:0]    out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [IDX_W-1:0]      out_src_q, out_src_d;
    logic                  err_q, err_d;

    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  can_load;
    logic [DW-1:0]         cur_word;
    logic [CRCW-1:0]       crc_nxt;
    logic [LEN_W-1:0]      len_inc;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req     (REQ_VALID),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Single output slot: it can take a new beat when empty or draining.
    assign can_load = !out_valid_q || OUT_READY;
    assign cur_word = REQ_DATA[g_q*DW +: DW];
    assign crc_nxt  = crc4_step(crc_q, cur_word);
    assign len_inc  = len_q + LEN_W'(1);

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        rr_ptr_d    = rr_ptr_q;
        crc_d       = crc_q;
        len_d       = len_q;
        out_valid_d = out_valid_q && !OUT_READY;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        err_d       = 1'b0;
        REQ_READY   = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    g_d     = pick_idx;
                    crc_d   = '0;
                    len_d   = '0;
                    state_d = DATA;
                end
            end

            DATA: begin
                REQ_READY = can_load ? (N_REQ'(1) << g_q) : '0;
                if (REQ_VALID[g_q] && can_load) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {cur_word, crc_nxt};
                    out_last_d  = 1'b0;
                    out_src_d   = g_q;
                    crc_d       = crc_nxt;
                    len_d       = len_inc;
                    if (REQ_LAST[g_q] || (len_inc == LEN_MAX)) begin
                        state_d = TRAIL;
                        // Forced close: leftover words become a new packet.
                        err_d   = !REQ_LAST[g_q];
                    end
                end
            end

            TRAIL: begin
                if (can_load) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {{DW{1'b0}}, crc_q};
                    out_last_d  = 1'b1;
                    out_src_d   = g_q;
                    rr_ptr_d    = (g_q == LAST_IDX) ? '0 : g_q + IDX_W'(1);
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Reset also clears the output beat so a packet cut by reset leaves no
    // partial beat behind.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            g_q         <= '0;
            rr_ptr_q    <= '0;
            crc_q       <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            rr_ptr_q    <= rr_ptr_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
            err_q       <= err_d;
        end
    end

    assign OUT_VALID   = out_valid_q;
    assign OUT_DATA    = out_data_q;
    assign OUT_LAST    = out_last_q;
    assign OUT_SRC     = out_src_q;
    assign ERR_OVERLEN = err_q;

`ifdef CRC_ARB_PKTCNT_EN
    logic [15:0] pkt_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pkt_cnt_q <= '0;
        end else if (out_valid_q && OUT_READY && out_last_q) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign PKT_CNT = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_crc_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_crc_share_arbiter
// Directed and randomized stimulus for crc_share_arbiter. Each requester's
// words are turned into an expected beat list by a packet-level model
// (running CRC by polynomial division, close on LAST or MAX_LEN); output
// beats are matched against the list of the source they report.
// -----------------------------------------------------------------------------
module tb_crc_share_arbiter;

    localparam int N    = 4;
    localparam int MAXL = 16;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   REQ_VALID;
    logic [N-1:0]   REQ_LAST;
    logic [N*32-1:0] REQ_DATA;
    logic [N-1:0]   REQ_READY;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic [35:0]    OUT_DATA;
    logic           OUT_LAST;
    logic [1:0]     OUT_SRC;
    logic           ERR_OVERLEN;
`ifdef CRC_ARB_PKTCNT_EN
    logic [15:0]    PKT_CNT;
`endif

    crc_share_arbiter #(
        .N_REQ   (N),
        .MAX_LEN (MAXL)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REQ_VALID   (REQ_VALID),
        .REQ_LAST    (REQ_LAST),
        .REQ_DATA    (REQ_DATA),
        .REQ_READY   (REQ_READY),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_DATA    (OUT_DATA),
        .OUT_LAST    (OUT_LAST),
        .OUT_SRC     (OUT_SRC),
        .ERR_OVERLEN (ERR_OVERLEN)
`ifdef CRC_ARB_PKTCNT_EN
        ,
        .PKT_CNT     (PKT_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [32:0] inq  [N][$];   // {last, word} waiting to be offered
    logic [36:0] expq [N][$];   // {last, data36} expected beats per source
    logic [3:0]  m_crc [N];
    int          m_len [N];
    int          exp_err, err_seen, err_at, acc_cnt, open_src;
    logic [36:0] logq [$];
    int          logsrc [$];
    int          gap_pct, stall_pct;
    bit          stall_force, prev_stall;
    logic [36:0] held;
    logic [1:0]  held_src;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC-4 (x^4+x+1) update as the remainder of crc*x^32 + word*x^4.
    function automatic logic [3:0] ref_crc(input logic [3:0] c, input logic [31:0] w);
        logic [39:0] v;
        v = {4'b0, c, 32'b0} ^ {4'b0, w, 4'b0};
        for (int i = 35; i >= 4; i--)
            if (v[i]) v = v ^ (40'h13 << (i - 4));
        return v[3:0];
    endfunction

    task automatic send_word(input int s, input logic [31:0] w, input bit l);
        inq[s].push_back({l, w});
        m_crc[s] = ref_crc(m_crc[s], w);
        m_len[s]++;
        expq[s].push_back({1'b0, w, m_crc[s]});
        if (l || m_len[s] == MAXL) begin
            expq[s].push_back({1'b1, 32'h0, m_crc[s]});
            if (!l) exp_err++;
            m_crc[s] = '0;
            m_len[s] = 0;
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < N; s++) begin
            inq[s].delete();
            expq[s].delete();
            m_crc[s] = '0;
            m_len[s] = 0;
        end
        exp_err = 0; err_seen = 0; err_at = -1; acc_cnt = 0; open_src = -1;
        prev_stall = 1'b0;
        logq.delete();
        logsrc.delete();
    endtask

    function automatic bit busy();
        bit b = 1'b0;
        for (int s = 0; s < N; s++)
            if (inq[s].size() > 0 || expq[s].size() > 0) b = 1'b1;
        return b;
    endfunction

    // One clock: drive at negedge, sample 1ns later, commit at posedge.
    task automatic step();
        logic [N-1:0] hs;
        int           s;
        for (int i = 0; i < N; i++) begin
            if (inq[i].size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
                REQ_VALID[i]         = 1'b1;
                REQ_LAST[i]          = inq[i][0][32];
                REQ_DATA[i*32 +: 32] = inq[i][0][31:0];
            end else begin
                REQ_VALID[i]         = 1'b0;
                REQ_LAST[i]          = 1'($urandom_range(1));
                REQ_DATA[i*32 +: 32] = $urandom;
            end
        end
        OUT_READY = stall_force ? 1'b0 : (int'($urandom_range(99)) >= stall_pct);
        #1;
        chk("ready_onehot", 64'($countones(REQ_READY) <= 1), 64'd1);
        if (prev_stall) begin
            chk("hold_valid", OUT_VALID, 1'b1);
            chk("hold_beat", {OUT_LAST, OUT_DATA}, held);
            chk("hold_src", OUT_SRC, held_src);
        end
        prev_stall = OUT_VALID && !OUT_READY;
        if (prev_stall) begin
            held     = {OUT_LAST, OUT_DATA};
            held_src = OUT_SRC;
            chk("stall_ready", REQ_READY, '0);
        end
        if (ERR_OVERLEN === 1'b1) begin
            err_seen++;
            err_at = logq.size();
        end
        if (OUT_VALID && OUT_READY) begin
            s = int'(OUT_SRC);
            chk("beat_pending", 64'(expq[s].size() > 0), 64'd1);
            if (expq[s].size() > 0) chk("beat", {OUT_LAST, OUT_DATA}, expq[s].pop_front());
            if (open_src >= 0) chk("no_interleave", 64'(s), 64'(open_src));
            open_src = OUT_LAST ? -1 : s;
            logq.push_back({OUT_LAST, OUT_DATA});
            logsrc.push_back(s);
        end
        hs = REQ_VALID & REQ_READY;
        @(posedge CLK);
        for (int i = 0; i < N; i++)
            if (hs[i]) begin
                void'(inq[i].pop_front());
                acc_cnt++;
            end
        @(negedge CLK);
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (busy() && c < budget) begin
            step();
            c++;
        end
        chk("drain_done", 64'(busy()), 64'd0);
    endtask

    task automatic do_reset(input bit check_out);
        RST       = 1'b1;
        REQ_VALID = '0;
        REQ_LAST  = '0;
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        if (check_out) begin
            chk("rst_ready", REQ_READY, '0);
            chk("rst_valid", OUT_VALID, 1'b0);
            chk("rst_data", OUT_DATA, '0);
            chk("rst_last", OUT_LAST, 1'b0);
            chk("rst_src", OUT_SRC, '0);
            chk("rst_err", ERR_OVERLEN, 1'b0);
        end
        @(negedge CLK);
        RST = 1'b0;
        clear_model();
    endtask

    initial begin
        int len;
        RST = 1'b1; REQ_VALID = '0; REQ_LAST = '0; REQ_DATA = '0; OUT_READY = 1'b1;
        gap_pct = 0; stall_pct = 0; stall_force = 1'b0;
        clear_model();
        @(negedge CLK);

        // Reset values, then a one-word packet.
        do_reset(1'b1);
        send_word(0, 32'h1, 1'b1);
        drain(50);
        chk("one_word_beats", logq.size(), 2);
        if (logq.size() == 2) begin
            chk("one_word_b1", logq[0], {1'b0, 32'h1, 4'b0011});
            chk("one_word_b1_src", logsrc[0], 0);
            chk("one_word_b2", logq[1], {1'b1, 32'h0, 4'b0011});
        end

        // Two competing packets from 0 and 2, then 1 and 3 with pointer at 3.
        do_reset(1'b0);
        send_word(0, 32'h0, 1'b0); send_word(0, 32'h0, 1'b1);
        send_word(2, 32'h0, 1'b0); send_word(2, 32'h0, 1'b1);
        drain(100);
        chk("rr_beats", logq.size(), 6);
        for (int i = 0; i < 6 && i < logsrc.size(); i++)
            chk("rr_order", logsrc[i], (i < 3) ? 0 : 2);
        send_word(1, 32'hA5A5_0001, 1'b1);
        send_word(3, 32'h5A5A_0003, 1'b1);
        drain(100);
        if (logsrc.size() == 10) begin
            chk("rr_ptr_first", logsrc[6], 3);
            chk("rr_ptr_second", logsrc[8], 1);
        end else chk("rr_ptr_beats", logsrc.size(), 10);

        // 20 words without LAST: forced close after 16.
        do_reset(1'b0);
        for (int k = 0; k < 20; k++) send_word(1, $urandom, 1'b0);
        drain(200);
        chk("ovl_err_cnt", err_seen, 1);
        chk("ovl_err_model", err_seen, exp_err);
        chk("ovl_err_at", err_at, 15);
        chk("ovl_beats", logq.size(), 21);
        if (logq.size() == 21) chk("ovl_trailer", logq[16][36], 1'b1);

        // Output held off for 5 cycles mid-packet.
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) send_word(2, $urandom, k == 5);
        for (int k = 0; k < 4; k++) step();
        stall_force = 1'b1;
        for (int k = 0; k < 5; k++) step();
        stall_force = 1'b0;
        drain(100);
        chk("stall_beats", logq.size(), 7);

        // Reset in DATA after two words; next packet CRC restarts from 0.
        do_reset(1'b0);
        send_word(0, 32'h1234_5678, 1'b0);
        send_word(0, 32'h9ABC_DEF0, 1'b0);
        send_word(0, 32'h0F0F_0F0F, 1'b1);
        for (int c = 0; c < 50 && acc_cnt < 2; c++) step();
        chk("mid_rst_accepts", acc_cnt, 2);
        do_reset(1'b1);
        send_word(0, 32'h2, 1'b1);
        drain(50);
        chk("post_rst_beats", logq.size(), 2);
        if (logq.size() == 2) begin
            chk("post_rst_b1", logq[0], {1'b0, 32'h2, 4'b0110});
            chk("post_rst_b2", logq[1], {1'b1, 32'h0, 4'b0110});
        end

        // Randomized traffic with input gaps and output backpressure.
        do_reset(1'b0);
        gap_pct = 25; stall_pct = 30;
        for (int s = 0; s < N; s++)
            for (int p = 0; p < 5; p++) begin
                len = int'($urandom_range(20, 1));
                for (int k = 0; k < len; k++) send_word(s, $urandom, k == len - 1);
            end
        drain(20000);
        chk("rand_err_cnt", err_seen, exp_err);
        gap_pct = 0; stall_pct = 0;

`ifdef CRC_ARB_PKTCNT_EN
        do_reset(1'b0);
        for (int s = 0; s < 3; s++) send_word(s, $urandom, 1'b1);
        drain(100);
        chk("pktcnt_3", PKT_CNT, 16'd3);
        force dut.pkt_cnt_q = 16'hFFFF;
        @(negedge CLK);
        release dut.pkt_cnt_q;
        send_word(3, $urandom, 1'b1);
        drain(100);
        chk("pktcnt_wrap", PKT_CNT, 16'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/crc_share_arbiter.md
Name: crc_share_arbiter

Overview:
- Shares one CRC-4 engine between N_REQ packet sources using round-robin arbitration.
- A grant is locked for a whole packet.
- Each granted packet is streamed out as data beats of {word, running CRC}, followed by one trailer beat that carries the final CRC.
- The block sits between the upstream word producers and the link/serializer stage that consumes 36-bit {data, crc} words.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 32, data word width. Fixed by the CRC step function.
- CRCW, 4, CRC width. Fixed.
- MAX_LEN, 16, maximum words per packet before a forced close (2..256).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- REQ_VALID  in  N_REQ  per-requester word valid.
- REQ_LAST  in  N_REQ  per-requester last-word flag, qualified by REQ_VALID.
- REQ_DATA  in  N_REQ*DW  requester i's word occupies bits [i*DW +: DW].
- REQ_READY  out  N_REQ  word accepted when REQ_VALID[i] & REQ_READY[i].
- OUT_VALID  out  1  output beat valid.
- OUT_READY  in  1  downstream accept.
- OUT_DATA  out  DW+CRCW  data beat {word, crc_after_word}; trailer beat {DW'b0, crc_final}.
- OUT_LAST  out  1  high on the trailer beat only.
- OUT_SRC  out  clog2(N_REQ)  index of the granted requester, valid with OUT_VALID.
- ERR_OVERLEN  out  1  one-cycle pulse when a packet is force-closed at MAX_LEN.

Interface rule (already decided): reset RST, synchronous, active-high; clock CLK.

Behaviour:
- Reset values:
  - All REQ_READY=0, OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, OUT_SRC=0, ERR_OVERLEN=0.
  - State=IDLE, rr_ptr=0, crc=4'b0000, len=0.
- A reset asserted mid-packet aborts the packet immediately. No trailer is emitted and the partial output beat is dropped.
- CRC step:
  - crc_next = crc4_step(crc, word): polynomial x^4+x+1, 32 data bits per step, init 4'b0000, no final XOR.
  - crc4_step(0, 32'h1)=4'b0011; crc4_step(0, 32'h2)=4'b0110; crc4_step(0, 0)=4'b0000.
- Output register: one entry, "empty" means OUT_VALID=0. can_load = !OUT_VALID | OUT_READY.
- IDLE state:
  - All REQ_READY=0.
  - If any REQ_VALID is high, grant the first requester at or after rr_ptr, searching upward with wrap.
  - On a grant: latch g, clear crc to 0 and len to 0, go to DATA. The grant costs one cycle.
- DATA state:
  - REQ_READY[g]=can_load; all others are 0.
  - On accept:
    - OUT_DATA={word, crc_next}, OUT_SRC=g, OUT_VALID=1.
    - crc<=crc_next, len<=len+1.
    - Data latency from accept to OUT_VALID is one cycle.
  - If REQ_LAST is high, or len+1==MAX_LEN, go to TRAIL.
  - In the MAX_LEN case without LAST, pulse ERR_OVERLEN in the same cycle. The requester's remaining words then form a new packet under later arbitration.
- TRAIL state:
  - REQ_READY=0.
  - When can_load: OUT_DATA={0, crc}, OUT_LAST=1, OUT_VALID=1.
  - Then set rr_ptr=(g+1) mod N_REQ and go to IDLE.
  - Arbitration for the next packet starts in the IDLE cycle after that, so back-to-back packets have a one-cycle bubble on the input side only.
- Backpressure:
  - While OUT_VALID=1 and OUT_READY=0, OUT_DATA, OUT_LAST and OUT_SRC must hold stable.
  - No input is accepted while the output is stalled.
- A one-word packet (LAST on the first word) produces exactly 2 output beats.
- A requester dropping REQ_VALID mid-packet keeps the grant. The block waits indefinitely and no other requester is served.
- REQ_LAST while REQ_VALID=0 is ignored.

Optional Feature:
- Macro: CRC_ARB_PKTCNT_EN.
- When defined:
  - Adds output PKT_CNT [15:0], the count of trailer beats accepted downstream (OUT_VALID & OUT_READY & OUT_LAST).
  - The count wraps at 16'hFFFF to 0 and is reset to 0 by RST.
- When not defined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Package crc_arb_pkg holds:
  - DW=32 and CRCW=4 constants.
  - The state enum {IDLE, DATA, TRAIL}.
  - The function crc4_step(crc[3:0], d[31:0]).
- Sub-module rr_pick: combinational round-robin picker with inputs req[N_REQ] and ptr, and outputs gnt_idx and any. It is reused by other arbiters.

Test Plan:
- RST, then requester 0 sends a 1-word packet 32'h1 with LAST, OUT_READY=1. Expect beat1 {32'h1, 4'b0011}, OUT_SRC=0, LAST=0; beat2 {32'h0, 4'b0011}, LAST=1.
- Requesters 0 and 2 both valid, each with a 2-word packet of zeros. Expect packet 0 fully (3 beats, CRC 0) before packet 2, then rr_ptr=3 and OUT_SRC order 0,0,0,2,2,2.
- Requester 1 sends 20 words without LAST, MAX_LEN=16. Expect ERR_OVERLEN pulse on the 16th accept, then a trailer, then the remaining 4 words as a new packet after re-arbitration.
- OUT_READY held low for 5 cycles mid-packet. Expect OUT_DATA stable, REQ_READY=0, and no word lost or duplicated once released.
- RST asserted in DATA after 2 words. Expect all outputs at reset values the next cycle and no trailer; the next packet's CRC starts from 0 (32'h2 gives 4'b0110).
- CRC_ARB_PKTCNT_EN defined, 3 packets sent. Expect PKT_CNT=3; with the counter preloaded by force to 16'hFFFF, one more packet gives PKT_CNT=0.
